// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 key controller: receiver FSM state
// encoding, scan-code set 1 constants for the direction keys, and the
// parity/stop-bit levels of a PS/2 device frame.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2State_t;

   localparam logic [7:0] CODE_UP    = 8'h11;
   localparam logic [7:0] CODE_LEFT  = 8'h1E;
   localparam logic [7:0] CODE_DOWN  = 8'h1F;
   localparam logic [7:0] CODE_RIGHT = 8'h20;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] BREAK_MASK = 8'h80;

   localparam logic PARITY_PASS = 1'b1;
   localparam logic STOP_LEVEL  = 1'b1;

   // Odd parity: the eight data bits together with the parity bit must
   // contain an odd number of ones.
   function automatic logic oddParityOk(input logic [7:0] dataBits, input logic parityBit);
      return ((^dataBits) ^ parityBit) == PARITY_PASS;
   endfunction

endpackage

// File: rtl/ps2_key_controller_if.sv
// ps2_key_controller_if
// Bundles the raw PS/2 device lines and the decoded key outputs.
//   PS2Clock, PS2Data : raw device clock/data (asynchronous to Clock)
//   KeyCode           : last valid received byte
//   KeyValid          : one-cycle pulse when KeyCode updates
//   KeyBreak          : KeyCode[7]
//   FrameError        : one-cycle pulse on parity/stop/timeout failure
//   Up/Down/Left/Right: held-key direction levels
// Modport master is the device/consumer side, slave is the controller.
interface ps2_key_controller_if;

   logic       PS2Clock;
   logic       PS2Data;
   logic [7:0] KeyCode;
   logic       KeyValid;
   logic       KeyBreak;
   logic       FrameError;
   logic       Up;
   logic       Down;
   logic       Left;
   logic       Right;

   modport master (
      output PS2Clock, PS2Data,
      input  KeyCode, KeyValid, KeyBreak, FrameError, Up, Down, Left, Right
   );

   modport slave (
      input  PS2Clock, PS2Data,
      output KeyCode, KeyValid, KeyBreak, FrameError, Up, Down, Left, Right
   );

endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
// Brings the raw PS/2 clock and data lines into the Clock domain through
// two-flop synchronizers and detects PS/2 clock falling edges.
//   Clock, Reset_n : system clock, asynchronous active-low reset
//   ps2ClockRaw    : raw PS/2 clock
//   ps2DataRaw     : raw PS/2 data
//   fallEdge       : high for one cycle when the synchronized clock goes 1 -> 0
//   dataBit        : synchronized data, valid to sample when fallEdge is high
module ps2_sync_edge (
   input  logic Clock,
   input  logic Reset_n,
   input  logic ps2ClockRaw,
   input  logic ps2DataRaw,
   output logic fallEdge,
   output logic dataBit
);

   logic clkMeta;
   logic clkSync;
   logic clkPrev;
   logic dataMeta;
   logic dataSync;

   // Synchronizers and the previous-clock register all reset to 1, the idle
   // level of the PS/2 bus, so releasing reset never fakes a falling edge.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         clkMeta  <= 1'b1;
         clkSync  <= 1'b1;
         clkPrev  <= 1'b1;
         dataMeta <= 1'b1;
         dataSync <= 1'b1;
      end else begin
         clkMeta  <= ps2ClockRaw;
         clkSync  <= clkMeta;
         clkPrev  <= clkSync;
         dataMeta <= ps2DataRaw;
         dataSync <= dataMeta;
      end
   end

   assign fallEdge = clkPrev & ~clkSync;
   assign dataBit  = dataSync;

endmodule

// File: rtl/ps2_key_controller.sv
// ps2_key_controller
// Receives PS/2 device frames (start, 8 data LSB-first, odd parity, stop),
// reports each accepted byte, and tracks held arrow keys from scan-code set 1.
//   Clock   : system clock
//   Reset_n : asynchronous active-low reset
//   bus     : ps2_key_controller_if.slave (raw PS/2 lines in, key outputs out)
// Parameters CLK_HZ and TIMEOUT_US size the optional frame watchdog.
// Build option: define PS2_WATCHDOG_EN to abort a frame after a gap of
// CLK_HZ/1_000_000*TIMEOUT_US cycles without a PS/2 clock falling edge.
module ps2_key_controller
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 25_000_000,
   parameter int TIMEOUT_US = 2000
) (
   input logic                  Clock,
   input logic                  Reset_n,
   ps2_key_controller_if.slave  bus
);

   localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;

   // A watchdog shorter than two cycles could never see a falling edge.
   if (TIMEOUT_CYCLES < 2) begin : gBadConfig
      $error("ps2_key_controller: CLK_HZ/TIMEOUT_US give a timeout below 2 cycles");
   end

   logic       fallEdge;
   logic       dataBit;
   ps2State_t  state;
   logic [2:0] bitCount;
   logic [7:0] shiftReg;
   logic       parityOk;
   logic       watchdogFire;
   logic       stopEdge;
   logic       stopGood;
   logic       stopBad;
   logic [7:0] makeCode;
   logic       isBreak;
   logic [7:0] keyCodeReg;
   logic       keyValidReg;
   logic       frameErrorReg;
   logic       extFlag;
   logic       heldUp;
   logic       heldDown;
   logic       heldLeft;
   logic       heldRight;

   ps2_sync_edge uSyncEdge (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .ps2ClockRaw (bus.PS2Clock),
      .ps2DataRaw  (bus.PS2Data),
      .fallEdge    (fallEdge),
      .dataBit     (dataBit)
   );

`ifdef PS2_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wdCount;

   // Gap counter: measures cycles since the last falling edge while a frame
   // is in progress; it is held at zero whenever the receiver is idle.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wdCount <= '0;
      end else if (state == IDLE || fallEdge) begin
         wdCount <= '0;
      end else begin
         wdCount <= wdCount + 1'b1;
      end
   end

   assign watchdogFire = (state != IDLE) && !fallEdge &&
                         (wdCount == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign watchdogFire = 1'b0;
`endif

   // Frame receiver: every step is taken on a detected PS/2 clock falling
   // edge; only the watchdog can pull the FSM back to IDLE between edges.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         bitCount <= 3'd0;
         shiftReg <= 8'h00;
         parityOk <= 1'b0;
      end else if (watchdogFire) begin
         state    <= IDLE;
         bitCount <= 3'd0;
      end else if (fallEdge) begin
         case (state)
            IDLE: begin
               if (!dataBit) begin
                  state    <= DATA;
                  bitCount <= 3'd0;
               end
            end
            DATA: begin
               shiftReg <= {dataBit, shiftReg[7:1]};
               bitCount <= bitCount + 3'd1;
               if (bitCount == 3'd7) begin
                  state <= PARITY;
               end
            end
            PARITY: begin
               parityOk <= oddParityOk(shiftReg, dataBit);
               state    <= STOP;
            end
            STOP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign stopEdge = fallEdge && (state == STOP);
   assign stopGood = stopEdge && (dataBit == STOP_LEVEL) && parityOk;
   assign stopBad  = stopEdge && !((dataBit == STOP_LEVEL) && parityOk);
   assign makeCode = shiftReg & ~BREAK_MASK;
   assign isBreak  = |(shiftReg & BREAK_MASK);

   // Byte acceptance and key tracking. An 0xE0 prefix arms the extended
   // flag so the following byte is reported but never touches the held
   // keys. Frame errors leave code, held keys and the flag untouched.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         keyCodeReg    <= 8'h00;
         keyValidReg   <= 1'b0;
         frameErrorReg <= 1'b0;
         extFlag       <= 1'b0;
         heldUp        <= 1'b0;
         heldDown      <= 1'b0;
         heldLeft      <= 1'b0;
         heldRight     <= 1'b0;
      end else begin
         keyValidReg   <= stopGood;
         frameErrorReg <= stopBad | watchdogFire;
         if (stopGood) begin
            keyCodeReg <= shiftReg;
            if (shiftReg == CODE_EXT) begin
               extFlag <= 1'b1;
            end else if (extFlag) begin
               extFlag <= 1'b0;
            end else begin
               case (makeCode)
                  CODE_UP:    heldUp    <= ~isBreak;
                  CODE_DOWN:  heldDown  <= ~isBreak;
                  CODE_LEFT:  heldLeft  <= ~isBreak;
                  CODE_RIGHT: heldRight <= ~isBreak;
                  default:    ;
               endcase
            end
         end
      end
   end

   // Opposing keys cancel at the outputs; the held bits themselves persist.
   assign bus.KeyCode    = keyCodeReg;
   assign bus.KeyValid   = keyValidReg;
   assign bus.KeyBreak   = keyCodeReg[7];
   assign bus.FrameError = frameErrorReg;
   assign bus.Up         = heldUp & ~heldDown;
   assign bus.Down       = heldDown & ~heldUp;
   assign bus.Left       = heldLeft & ~heldRight;
   assign bus.Right      = heldRight & ~heldLeft;

endmodule

// File: tb/tb_ps2_key_controller.sv
// tb_ps2_key_controller
// Self-checking bench for ps2_key_controller: a vector table of frames with
// expected results pushed to a scoreboard queue, plus hand-written sequences
// for idle noise, the watchdog (when PS2_WATCHDOG_EN is defined) and reset.
module tb_ps2_key_controller;
   import ps2_pkg::*;

   logic Clock   = 1'b0;
   logic Reset_n = 1'b0;

   ps2_key_controller_if ps2Bus();

   ps2_key_controller #(
      .CLK_HZ     (1_000_000),
      .TIMEOUT_US (100)
   ) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (ps2Bus)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [7:0] code;
      bit         badParity;
      bit         badStop;
      bit         isErr;
      logic [7:0] expCode;
      logic [3:0] expDir;
   } vec_t;

   typedef struct {
      bit         isErr;
      logic [7:0] code;
      logic [3:0] dir;
   } expect_t;

   expect_t sbQueue[$];
   vec_t    vecs[19];
   int      checks = 0;
   int      errors = 0;

   // Single comparison point: every check steps the counters here.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Sends the first nBits bits of a frame. A complete 11-bit frame returns
   // right after the stop-bit clock drop so latency can be measured.
   task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                                input bit badStop, input int nBits);
      logic [10:0] frame;
      frame = {(badStop ? 1'b0 : 1'b1), ((~^code) ^ badParity), code, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         @(negedge Clock);
         ps2Bus.PS2Data = frame[i];
         repeat (4) @(negedge Clock);
         ps2Bus.PS2Clock = 1'b0;
         if (i != 10) begin
            repeat (8) @(negedge Clock);
            ps2Bus.PS2Clock = 1'b1;
         end
      end
   endtask

   // Waits (bounded) for the frame result, pops the scoreboard and compares.
   task automatic checkOutput(input string tag);
      expect_t exp;
      int      cycles;
      bit      seen;
      if (sbQueue.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard empty actual=0 expected=1 entries", tag);
      end else begin
         exp    = sbQueue.pop_front();
         cycles = 0;
         seen   = 1'b0;
         while (!seen && cycles < 40) begin
            @(negedge Clock);
            cycles++;
            if (ps2Bus.KeyValid === 1'b1 || ps2Bus.FrameError === 1'b1) seen = 1'b1;
         end
         checkVal({tag, " event"}, 32'(seen), 32'd1);
         if (seen) begin
            checkVal({tag, " latency"}, 32'(cycles), 32'd3);
            checkVal({tag, " KeyValid"}, 32'(ps2Bus.KeyValid), 32'(!exp.isErr));
            checkVal({tag, " FrameError"}, 32'(ps2Bus.FrameError), 32'(exp.isErr));
            checkVal({tag, " KeyCode"}, 32'(ps2Bus.KeyCode), 32'(exp.code));
            checkVal({tag, " KeyBreak"}, 32'(ps2Bus.KeyBreak), 32'(exp.code[7]));
            checkVal({tag, " UDLR"},
                     32'({ps2Bus.Up, ps2Bus.Down, ps2Bus.Left, ps2Bus.Right}),
                     32'(exp.dir));
            @(negedge Clock);
            checkVal({tag, " pulse width"},
                     32'({ps2Bus.KeyValid, ps2Bus.FrameError}), 32'd0);
         end
      end
      ps2Bus.PS2Clock = 1'b1;
      repeat (6) @(negedge Clock);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] simulation did not finish in time");
   end

   initial begin
      int noise;
      int errPulses;
      int validPulses;

      vecs[0]  = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 4'b1000};
      vecs[1]  = '{8'h91, 1'b0, 1'b0, 1'b0, 8'h91, 4'b0000};
      vecs[2]  = '{8'h1E, 1'b1, 1'b0, 1'b1, 8'h91, 4'b0000};
      vecs[3]  = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 4'b1000};
      vecs[4]  = '{8'h1F, 1'b0, 1'b0, 1'b0, 8'h1F, 4'b0000};
      vecs[5]  = '{8'h91, 1'b0, 1'b0, 1'b0, 8'h91, 4'b0100};
      vecs[6]  = '{8'h9F, 1'b0, 1'b0, 1'b0, 8'h9F, 4'b0000};
      vecs[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'hE0, 4'b0000};
      vecs[8]  = '{8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 4'b0000};
      vecs[9]  = '{8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 4'b0001};
      vecs[10] = '{8'h1E, 1'b0, 1'b0, 1'b0, 8'h1E, 4'b0000};
      vecs[11] = '{8'hA0, 1'b0, 1'b0, 1'b0, 8'hA0, 4'b0010};
      vecs[12] = '{8'h42, 1'b0, 1'b0, 1'b0, 8'h42, 4'b0010};
      vecs[13] = '{8'h9E, 1'b0, 1'b1, 1'b1, 8'h42, 4'b0010};
      vecs[14] = '{8'h9E, 1'b0, 1'b0, 1'b0, 8'h9E, 4'b0000};
      vecs[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'hE0, 4'b0000};
      vecs[16] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'hE0, 4'b0000};
      vecs[17] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 4'b0000};
      vecs[18] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 4'b1000};

      ps2Bus.PS2Clock = 1'b1;
      ps2Bus.PS2Data  = 1'b1;
      Reset_n         = 1'b0;
      repeat (3) @(negedge Clock);

      // Reset state
      checkVal("reset KeyCode", 32'(ps2Bus.KeyCode), 32'h00);
      checkVal("reset KeyValid", 32'(ps2Bus.KeyValid), 32'd0);
      checkVal("reset FrameError", 32'(ps2Bus.FrameError), 32'd0);
      checkVal("reset KeyBreak", 32'(ps2Bus.KeyBreak), 32'd0);
      checkVal("reset UDLR", 32'({ps2Bus.Up, ps2Bus.Down, ps2Bus.Left, ps2Bus.Right}), 32'd0);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clock);

      // Clock edges with data high while idle must produce nothing
      noise = 0;
      for (int e = 0; e < 3; e++) begin
         ps2Bus.PS2Data = 1'b1;
         repeat (4) @(negedge Clock);
         ps2Bus.PS2Clock = 1'b0;
         for (int c = 0; c < 8; c++) begin
            @(negedge Clock);
            if (ps2Bus.KeyValid || ps2Bus.FrameError) noise++;
         end
         ps2Bus.PS2Clock = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            if (ps2Bus.KeyValid || ps2Bus.FrameError) noise++;
         end
      end
      checkVal("idle data-high pulses", 32'(noise), 32'd0);

      // Table-driven frames
      for (int i = 0; i < 19; i++) begin
         sbQueue.push_back('{vecs[i].isErr, vecs[i].expCode, vecs[i].expDir});
         applyStimulus(vecs[i].code, vecs[i].badParity, vecs[i].badStop, 11);
         checkOutput($sformatf("vec%0d", i));
      end

`ifdef PS2_WATCHDOG_EN
      // Stall after 4 data bits: exactly one FrameError, no KeyValid
      applyStimulus(8'h5A, 1'b0, 1'b0, 5);
      errPulses   = 0;
      validPulses = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge Clock);
         if (ps2Bus.FrameError) errPulses++;
         if (ps2Bus.KeyValid) validPulses++;
      end
      checkVal("watchdog FrameError pulses", 32'(errPulses), 32'd1);
      checkVal("watchdog KeyValid pulses", 32'(validPulses), 32'd0);
      checkVal("watchdog state", 32'(dut.state), 32'(IDLE));
      checkVal("watchdog KeyCode", 32'(ps2Bus.KeyCode), 32'h11);
      sbQueue.push_back('{1'b0, 8'h20, 4'b1001});
      applyStimulus(8'h20, 1'b0, 1'b0, 11);
      checkOutput("after watchdog");
`else
      errPulses   = 0;
      validPulses = 0;
`endif

      // Reset mid-frame with Up held
      applyStimulus(8'h42, 1'b0, 1'b0, 4);
      Reset_n = 1'b0;
      #1;
      checkVal("midreset KeyCode", 32'(ps2Bus.KeyCode), 32'h00);
      checkVal("midreset KeyValid", 32'(ps2Bus.KeyValid), 32'd0);
      checkVal("midreset FrameError", 32'(ps2Bus.FrameError), 32'd0);
      checkVal("midreset KeyBreak", 32'(ps2Bus.KeyBreak), 32'd0);
      checkVal("midreset UDLR", 32'({ps2Bus.Up, ps2Bus.Down, ps2Bus.Left, ps2Bus.Right}), 32'd0);
      repeat (3) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clock);
      sbQueue.push_back('{1'b0, 8'h11, 4'b1000});
      applyStimulus(8'h11, 1'b0, 1'b0, 11);
      checkOutput("after reset");

      checkVal("scoreboard drained", 32'(sbQueue.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_controller.md
PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
Parameters:
REQ-001 CLK_HZ, 25_000_000, system clock frequency in Hz.
REQ-002 TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside one frame, in microseconds.
Ports:
REQ-003 Clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 PS2Clock  input  1  raw PS/2 device clock, asynchronous to Clock.
REQ-006 PS2Data  input  1  raw PS/2 device data, asynchronous to Clock.
REQ-007 KeyCode  output  8  last valid received byte, held until the next valid byte.
REQ-008 KeyValid  output  1  one-cycle pulse when KeyCode is updated.
REQ-009 KeyBreak  output  1  KeyCode[7], valid together with KeyValid.
REQ-010 FrameError  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.
REQ-011 Up, Down, Left, Right  output  1 each  held-key direction levels.

Function
REQ-012 PS2Clock and PS2Data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be a synchronized 1 followed by a synchronized 0.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP; all transitions SHALL occur only on a detected falling edge, except for the timeout.
REQ-014 IDLE: sampled data 0 -> DATA with bit count 0; sampled data 1 -> stay in IDLE, no output.
REQ-015 DATA: shift in 8 bits LSB-first; after the 8th bit -> PARITY.
REQ-016 PARITY: the 8 data bits XOR the parity bit SHALL equal 1 (odd parity); record pass/fail -> STOP.
REQ-017 STOP: data 1 with parity pass -> accept the byte; otherwise FrameError; in both cases -> IDLE.
REQ-018 Latency: KeyValid (or FrameError) SHALL assert in the cycle after the stop-bit edge is detected; KeyCode, KeyBreak and the direction outputs SHALL update in that same cycle.
REQ-019 Scan-code set 1 handling: make code sets the held bit, make|0x80 clears it; 0x11 Up, 0x1E Left, 0x1F Down, 0x20 Right.
REQ-020 Byte 0xE0 SHALL set an extended flag and pulse KeyValid; the next accepted byte SHALL be reported with KeyValid but SHALL NOT change held bits, and SHALL clear the flag.
REQ-021 Unmapped codes SHALL pulse KeyValid and leave the held bits unchanged.
REQ-022 If both keys of an opposing pair (Up/Down or Left/Right) are held, both outputs of that pair SHALL be 0, and the held bits SHALL be kept.
REQ-023 A frame error SHALL NOT change KeyCode, the held bits or the extended flag.

Reset
REQ-024 Reset_n low SHALL immediately force state IDLE, all counters 0, KeyCode 0x00, all pulses 0, all held bits and direction outputs 0, extended flag 0, and synchronizers 1.
REQ-025 A reset mid-frame SHALL discard the partial frame; the first frame after release SHALL be received normally.

Configuration
REQ-026 Macro PS2_WATCHDOG_EN defined: in a non-IDLE state, a gap of CLK_HZ/1_000_000*TIMEOUT_US cycles with no falling edge SHALL force IDLE and pulse FrameError once; the counter SHALL clear on every falling edge and in IDLE.
REQ-027 PS2_WATCHDOG_EN undefined: no timeout counter SHALL exist; the FSM SHALL wait indefinitely for edges.

Structure
REQ-028 Package ps2_pkg SHALL hold the FSM state enum, the scan-code constants (up, left, down, right, extended prefix, break mask) and the parity/stop constants.
REQ-029 Sub-module ps2_sync_edge SHALL implement the synchronizer and falling-edge detection, and is instantiated once for the clock/data pair.

Verification
REQ-030 Frame 0x11 with correct parity -> KeyValid pulse, KeyCode=0x11, KeyBreak=0, Up=1; then frame 0x91 -> KeyBreak=1, Up=0.
REQ-031 Frame 0x1E with the parity bit inverted -> FrameError pulse, no KeyValid, Left stays 0, KeyCode unchanged.
REQ-032 Hold 0x11, then 0x1F -> Up=0 and Down=0; then 0x91 -> Down=1.
REQ-033 Frames 0xE0 then 0x20 -> two KeyValid pulses, KeyCode=0x20, Right stays 0; a following 0x20 -> Right=1.
REQ-034 With PS2_WATCHDOG_EN defined, stop the clock after 4 data bits for longer than TIMEOUT_US -> one FrameError pulse, state IDLE; the next complete frame 0x20 -> Right=1.
REQ-035 Assert Reset_n low mid-frame with Up held -> all outputs 0 immediately; after release, frame 0x11 -> Up=1.
